// File: rtl/display_pkg.sv
// Shared constants and types for the micro-display pipeline.
// Holds the 640x400 raster timing, palette code field positions and pixel types.
// Ports: none (package).
package display_pkg;

  localparam int H_ACTIVE = 640;
  localparam int H_FP     = 16;
  localparam int H_SYNC   = 64;
  localparam int H_BP     = 138;
  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;

  localparam int V_ACTIVE = 400;
  localparam int V_FP     = 58;
  localparam int V_SYNC   = 3;
  localparam int V_BP     = 64;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

  // Raster counters must hold H_TOTAL-1 / V_TOTAL-1; address must hold 640*400.
  localparam int CNT_W  = 10;
  localparam int ADDR_W = 18;

  // Palette code layout: [9:6]=Y, [5:3]=Cb, [2:0]=Cr
  localparam int Y_MSB  = 9;
  localparam int Y_LSB  = 6;
  localparam int CB_MSB = 5;
  localparam int CB_LSB = 3;
  localparam int CR_MSB = 2;
  localparam int CR_LSB = 0;

  // Counter-to-pin latency in clocks
  localparam int PIPE_LAT = 3;

  typedef logic [9:0] color_code_t;
  typedef logic [3:0] color_idx_t;

  // Black: Y=0, Cb=Cr=mid-scale
  localparam color_code_t BLANK_CODE = 10'h024;

endpackage

// File: rtl/display_palette.sv
// 16-entry palette mapping 4-bit colour indices to 10-bit YCbCr codes.
// Ports: clk/reset (sync, active-high); wr_en/wr_idx/wr_code write port;
//        rd_idx in, rd_code out one clock later (registered read).
module display_palette
  import display_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       wr_en,
  input  logic [3:0] wr_idx,
  input  logic [9:0] wr_code,
  input  logic [3:0] rd_idx,
  output logic [9:0] rd_code
);

  color_code_t mem [16];

  // Read and write share an edge: a same-index read returns the code held
  // before this edge, the new code is seen from the following read.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 16; i++) begin
        mem[i] <= BLANK_CODE;
      end
      rd_code <= BLANK_CODE;
    end else begin
      if (wr_en) begin
        mem[wr_idx] <= wr_code;
      end
      rd_code <= mem[rd_idx];
    end
  end

endmodule

// File: rtl/display_pipeline.sv
// Micro-display driver: raster timing, frame-buffer addressing, palette lookup, pin registers.
// Ports: clk, reset (sync, active-high), ready gates frame start; wr_* palette write port;
//        rd_addr/rd_data frame-buffer read (1-clk latency); clock_out, hsync, vsync, y/cb/cr pins.
module display_pipeline
  import display_pkg::*;
#(
  parameter int H_ACTIVE = display_pkg::H_ACTIVE,
  parameter int H_FP     = display_pkg::H_FP,
  parameter int H_SYNC   = display_pkg::H_SYNC,
  parameter int H_BP     = display_pkg::H_BP,
  parameter int V_ACTIVE = display_pkg::V_ACTIVE,
  parameter int V_FP     = display_pkg::V_FP,
  parameter int V_SYNC   = display_pkg::V_SYNC,
  parameter int V_BP     = display_pkg::V_BP
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ready,
  input  logic        wr_en,
  input  logic [3:0]  wr_color_idx,
  input  logic [9:0]  wr_color_code,
  output logic [17:0] rd_addr,
  input  logic [3:0]  rd_data,
  output logic        clock_out,
  output logic        hsync,
  output logic        vsync,
  output logic [3:0]  y,
  output logic [2:0]  cb,
  output logic [2:0]  cr
);

  typedef logic [CNT_W-1:0]  cnt_t;
  typedef logic [ADDR_W-1:0] addr_t;

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam cnt_t H_ACT_C = cnt_t'(H_ACTIVE);
  localparam cnt_t HS_BEG  = cnt_t'(H_ACTIVE + H_FP);
  localparam cnt_t HS_END  = cnt_t'(H_ACTIVE + H_FP + H_SYNC);
  localparam cnt_t H_LAST  = cnt_t'(H_TOTAL - 1);
  localparam cnt_t V_ACT_C = cnt_t'(V_ACTIVE);
  localparam cnt_t VS_BEG  = cnt_t'(V_ACTIVE + V_FP);
  localparam cnt_t VS_END  = cnt_t'(V_ACTIVE + V_FP + V_SYNC);
  localparam cnt_t V_LAST  = cnt_t'(V_TOTAL - 1);

  // ---------------- stage 0: raster counters and read address ----------------
  cnt_t h;
  cnt_t v;
  logic running;
  logic run_now;
  logic h_wrap;
  logic v_wrap;
  logic act0;
  logic hs0_n;
  logic vs0_n;

  // ready is only consulted at the frame origin, so a ready drop lets the
  // current frame finish and then parks the counters at (0,0).
  always_comb begin
    run_now = running;
    if ((h == '0) && (v == '0)) begin
      run_now = ready;
    end
    h_wrap = (h == H_LAST);
    v_wrap = (v == V_LAST);
    // The parked origin is not a displayed pixel, hence the run_now gate.
    act0   = run_now && (h < H_ACT_C) && (v < V_ACT_C);
    hs0_n  = !((h >= HS_BEG) && (h < HS_END));
    vs0_n  = !((v >= VS_BEG) && (v < VS_END));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      h       <= '0;
      v       <= '0;
      running <= 1'b0;
      rd_addr <= '0;
    end else begin
      running <= run_now;
      if (run_now) begin
        if (h_wrap) begin
          h <= '0;
          v <= v_wrap ? '0 : v + cnt_t'(1);
        end else begin
          h <= h + cnt_t'(1);
        end
        // Linear address: step after every active pixel, hold through
        // blanking, restart at the frame origin.
        if (h_wrap && v_wrap) begin
          rd_addr <= '0;
        end else if (act0) begin
          rd_addr <= rd_addr + addr_t'(1);
        end
      end
    end
  end

  // ---------------- stages 1-2: align region flags with pixel data ----------------
  // Index 0 travels with rd_data (stage 1), index PIPE_LAT-2 with the palette code (stage 2).
  logic [PIPE_LAT-2:0] act_d;
  logic [PIPE_LAT-2:0] hs_d;
  logic [PIPE_LAT-2:0] vs_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      act_d <= '0;
      hs_d  <= '1;
      vs_d  <= '1;
    end else begin
      act_d <= {act_d[PIPE_LAT-3:0], act0};
      hs_d  <= {hs_d[PIPE_LAT-3:0], hs0_n};
      vs_d  <= {vs_d[PIPE_LAT-3:0], vs0_n};
    end
  end

  color_code_t pal_code;

  display_palette u_palette (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (wr_en),
    .wr_idx  (wr_color_idx),
    .wr_code (wr_color_code),
    .rd_idx  (rd_data),
    .rd_code (pal_code)
  );

  // ---------------- stage 3: pin registers ----------------
  color_code_t pix_code;

  always_comb begin
    pix_code = act_d[PIPE_LAT-2] ? pal_code : BLANK_CODE;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hsync <= 1'b1;
      vsync <= 1'b1;
      y     <= BLANK_CODE[Y_MSB:Y_LSB];
      cb    <= BLANK_CODE[CB_MSB:CB_LSB];
      cr    <= BLANK_CODE[CR_MSB:CR_LSB];
    end else begin
      hsync <= hs_d[PIPE_LAT-2];
      vsync <= vs_d[PIPE_LAT-2];
      y     <= pix_code[Y_MSB:Y_LSB];
      cb    <= pix_code[CB_MSB:CB_LSB];
      cr    <= pix_code[CR_MSB:CR_LSB];
    end
  end

  // Panel samples on the falling edge of clk.
  assign clock_out = ~clk;

endmodule

// File: tb/tb_display_pipeline.sv
// Bench for display_pipeline: a reduced-raster instance driven with random palette writes and
// ready patterns against a pixel-level reference, plus a full-size instance for the first lines.
`timescale 1ns/1ps
module tb_display_pipeline;

  localparam int HA = 16, HFP = 4, HSW = 8, HBP = 6, HT = HA + HFP + HSW + HBP;
  localparam int VA = 10, VFP = 3, VSW = 2, VBP = 3, VT = VA + VFP + VSW + VBP;
  localparam int FT = HT * VT;
  localparam logic [9:0] BLANK = 10'h024;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // reduced-raster instance
  logic        reset, ready, wr_en;
  logic [3:0]  wr_color_idx;
  logic [9:0]  wr_color_code;
  logic [17:0] rd_addr;
  logic [3:0]  rd_data;
  logic        clock_out, hsync, vsync;
  logic [3:0]  y;
  logic [2:0]  cb, cr;

  // full-size instance
  logic        big_ready, big_wr_en;
  logic [3:0]  big_wr_idx, big_rd_data;
  logic [9:0]  big_wr_code;
  logic [17:0] big_addr;
  logic        big_clock_out, big_hsync, big_vsync;
  logic [3:0]  big_y;
  logic [2:0]  big_cb, big_cr;

  display_pipeline #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP)
  ) dut (
    .clk(clk), .reset(reset), .ready(ready), .wr_en(wr_en),
    .wr_color_idx(wr_color_idx), .wr_color_code(wr_color_code),
    .rd_addr(rd_addr), .rd_data(rd_data), .clock_out(clock_out),
    .hsync(hsync), .vsync(vsync), .y(y), .cb(cb), .cr(cr)
  );

  display_pipeline big (
    .clk(clk), .reset(reset), .ready(big_ready), .wr_en(big_wr_en),
    .wr_color_idx(big_wr_idx), .wr_color_code(big_wr_code),
    .rd_addr(big_addr), .rd_data(big_rd_data), .clock_out(big_clock_out),
    .hsync(big_hsync), .vsync(big_vsync), .y(big_y), .cb(big_cb), .cr(big_cr)
  );

  int n_checks = 0;
  int n_pass = 0;
  bit big_done = 0;

  logic [3:0]  fb_mem [1024];
  logic [9:0]  mpal [16];
  int          mh, mv;
  bit          mrun;
  logic [11:0] sb_q [$];
  logic [17:0] addr_q [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s at %0t: got %0h want %0h", name, $time, act, exp);
  endtask

  // Address of the next pixel to fetch: pixels already passed in this frame.
  function automatic logic [17:0] exp_addr(input int h, input int v);
    int n;
    if (v >= VA)     n = VA * HA;
    else if (h < HA) n = v * HA + h;
    else             n = (v + 1) * HA;
    return 18'(n);
  endfunction

  task automatic model_reset();
    mh = 0; mv = 0; mrun = 0;
    for (int i = 0; i < 16; i++) mpal[i] = BLANK;
    for (int i = 0; i < 3; i++) sb_q.push_back({2'b11, BLANK});
  endtask

  task automatic do_reset();
    sb_q.delete();
    addr_q.delete();
    wr_en = 0;
    reset = 1;
    @(posedge clk); #1;
    check("rst_pins_e1", 32'({hsync, vsync, y, cb, cr}), 32'({2'b11, BLANK}));
    check("rst_addr_e1", 32'(rd_addr), 32'd0);
    @(posedge clk); #1;
    reset = 0;
    check("rst_pins", 32'({hsync, vsync, y, cb, cr}), 32'({2'b11, BLANK}));
    check("rst_addr", 32'(rd_addr), 32'd0);
    check("clock_out_hi", 32'(clock_out), 32'd0);
    model_reset();
  endtask

  // One clock of stimulus; the expected pins for the current raster position are queued.
  task automatic cycle(input logic rdy, input bit allow_wr);
    bit run_now, act, hs_n, vs_n;
    logic [17:0] a;
    logic [3:0]  ix;
    ready = rdy;
    if (allow_wr && $urandom_range(0, 3) == 0) begin
      wr_en = 1;
      wr_color_idx = 4'($urandom_range(0, 15));
      wr_color_code = ($urandom_range(0, 7) == 0) ? 10'h3FF : 10'($urandom_range(0, 1023));
      // This pixel's palette read happens two edges later, so this write is visible to it.
      mpal[wr_color_idx] = wr_color_code;
    end else begin
      wr_en = 0;
    end
    run_now = (mh == 0 && mv == 0) ? rdy : mrun;
    act  = run_now && (mh < HA) && (mv < VA);
    hs_n = !(mh >= HA + HFP && mh < HA + HFP + HSW);
    vs_n = !(mv >= VA + VFP && mv < VA + VFP + VSW);
    a = exp_addr(mh, mv);
    addr_q.push_back(a);
    ix = fb_mem[a[9:0]];
    sb_q.push_back({hs_n, vs_n, act ? mpal[ix] : BLANK});
    if (run_now) begin
      mh++;
      if (mh == HT) begin
        mh = 0;
        mv++;
        if (mv == VT) mv = 0;
      end
    end
    mrun = run_now;
    @(posedge clk); #1;
  endtask

  // Frame buffer: returns the word at the address presented during the previous clock.
  initial begin : fbuf
    logic [17:0] a;
    rd_data = 0;
    forever begin
      @(negedge clk);
      a = rd_addr;
      @(posedge clk);
      #1 rd_data = fb_mem[a[9:0]];
    end
  end

  // Monitor: address is checked in its own cycle, pins three clocks after issue.
  initial begin : mon
    logic [11:0] ep;
    logic [17:0] ea;
    forever begin
      @(negedge clk);
      if (addr_q.size() > 0) begin
        ea = addr_q.pop_front();
        check("rd_addr", 32'(rd_addr), 32'(ea));
      end
      if (sb_q.size() > 3) begin
        ep = sb_q.pop_front();
        check("pins", 32'({hsync, vsync, y, cb, cr}), 32'(ep));
      end
    end
  end

  // Full-size raster: first two lines of addressing and hsync placement.
  initial begin : big_chk
    int  low_cnt;
    bit  vs_low;
    low_cnt = 0;
    vs_low = 0;
    @(negedge reset);
    for (int k = 0; k < 1800; k++) begin
      @(negedge clk);
      if (k == 0)         check("big_addr_0_0", 32'(big_addr), 32'd0);
      if (k == 5)         check("big_clock_out", 32'(big_clock_out), 32'd1);
      if (k == 10)        check("big_pins_blank_idx0", 32'({big_hsync, big_vsync, big_y, big_cb, big_cr}), 32'({2'b11, BLANK}));
      if (k == 639)       check("big_addr_639_0", 32'(big_addr), 32'd639);
      if (k == 640)       check("big_addr_hold", 32'(big_addr), 32'd640);
      if (k == 858)       check("big_addr_0_1", 32'(big_addr), 32'd640);
      if (k == 858 + 639) check("big_addr_639_1", 32'(big_addr), 32'd1279);
      if (k == 658)       check("big_hs_before", 32'(big_hsync), 32'd1);
      if (k == 659)       check("big_hs_first", 32'(big_hsync), 32'd0);
      if (k == 722)       check("big_hs_last", 32'(big_hsync), 32'd0);
      if (k == 723)       check("big_hs_after", 32'(big_hsync), 32'd1);
      if (k >= 3 && k < 858 + 3 && !big_hsync) low_cnt++;
      if (!big_vsync) vs_low = 1;
    end
    check("big_hs_width", 32'(low_cnt), 32'd64);
    check("big_vs_idle", 32'(vs_low), 32'd0);
    big_done = 1;
  end

  initial begin : drive
    for (int i = 0; i < 1024; i++) fb_mem[i] = 4'($urandom_range(0, 15));
    reset = 1; ready = 0; wr_en = 0; wr_color_idx = 0; wr_color_code = 0;
    big_ready = 1; big_wr_en = 0; big_wr_idx = 0; big_wr_code = 0; big_rd_data = 0;
    do_reset();
    repeat (40) cycle(1'b0, 1'b1);          // parked: counters hold, writes still land
    repeat (3 * FT + 250) cycle(1'b1, 1'b1); // several frames, ends mid-frame
    repeat (800) cycle(1'b0, 1'b1);          // ready drop: frame completes then parks
    repeat (900) cycle(1'b1, 1'b1);          // resume
    do_reset();                              // reset mid-frame, palette included
    repeat (FT + 100) cycle(1'b1, 1'b1);
    wr_en = 0;
    repeat (4) @(posedge clk);
    wait (big_done);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
